// File: rtl/jk_bank_driver_if.sv
// rtl/jk_bank_driver_if.sv - command, bank drive/readback and status signals of jk_bank_driver
// master is the driver block; slave is the command source plus the JK bank.
interface jk_bank_driver_if #(
  parameter int WIDTH = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_target;
  logic [WIDTH-1:0] q_in;
  logic [WIDTH-1:0] j_out;
  logic [WIDTH-1:0] k_out;
  logic             done;
  logic             err;
  logic [WIDTH-1:0] fail_mask;
  logic [15:0]      drive_count;

  modport master (
    input  cmd_valid, cmd_target, q_in,
    output cmd_ready, j_out, k_out, done, err, fail_mask, drive_count
  );

  modport slave (
    output cmd_valid, cmd_target, q_in,
    input  cmd_ready, j_out, k_out, done, err, fail_mask, drive_count
  );
endinterface

// File: rtl/jk_bank_driver.sv
// rtl/jk_bank_driver.sv - drives J/K of an external JK flip-flop bank toward a target word
// Each attempt is one DRIVE cycle followed by one CHECK cycle against the Q readback.
module jk_bank_driver #(
  parameter int WIDTH      = 8,
  parameter int MAX_RETRY  = 2,
  parameter int USE_TOGGLE = 0
) (
  input logic               clk,
  input logic               rst,
  jk_bank_driver_if.master  bus
);
  typedef enum logic [1:0] {IDLE, DRIVE, CHECK} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] tgt, tgt_n;
  logic [WIDTH-1:0] j_q, j_n, k_q, k_n;
  logic             done_q, done_n, err_q, err_n;
  logic [WIDTH-1:0] mask_q, mask_n;
  logic [15:0]      cnt_q, cnt_n;
  logic [3:0]       retry, retry_n;
  logic [WIDTH-1:0] exc_src, exc_j, exc_k;

  // In IDLE the excitation targets the incoming word; on a retry it targets the latched one.
  assign exc_src = (state == IDLE) ? bus.cmd_target : tgt;

  // Unknown readback bits fall back to set/reset so the result never depends on the old value.
  always_comb begin
    exc_j = '0;
    exc_k = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if ($isunknown(bus.q_in[i])) begin
        exc_j[i] = exc_src[i];
        exc_k[i] = ~exc_src[i];
      end else if (bus.q_in[i] != exc_src[i]) begin
        if (USE_TOGGLE != 0) begin
          exc_j[i] = 1'b1;
          exc_k[i] = 1'b1;
        end else begin
          exc_j[i] = exc_src[i];
          exc_k[i] = ~exc_src[i];
        end
      end
    end
  end

  always_comb begin
    state_n = state;
    tgt_n   = tgt;
    j_n     = '0;
    k_n     = '0;
    done_n  = 1'b0;
    err_n   = err_q;
    mask_n  = mask_q;
    cnt_n   = cnt_q;
    retry_n = retry;
    case (state)
      IDLE: begin
        if (bus.cmd_valid) begin
          tgt_n   = bus.cmd_target;
          retry_n = '0;
          j_n     = exc_j;
          k_n     = exc_k;
          state_n = DRIVE;
        end
      end
      DRIVE: begin
        if (cnt_q != 16'hFFFF) cnt_n = cnt_q + 16'd1;
        state_n = CHECK;
      end
      CHECK: begin
        if (bus.q_in == tgt) begin
          done_n  = 1'b1;
          err_n   = 1'b0;
          mask_n  = '0;
          state_n = IDLE;
        end else if (retry < 4'(MAX_RETRY)) begin
          retry_n = retry + 4'd1;
          j_n     = exc_j;
          k_n     = exc_k;
          state_n = DRIVE;
        end else begin
          done_n  = 1'b1;
          err_n   = 1'b1;
          mask_n  = bus.q_in ^ tgt;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      tgt    <= '0;
      j_q    <= '0;
      k_q    <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      mask_q <= '0;
      cnt_q  <= '0;
      retry  <= '0;
    end else begin
      state  <= state_n;
      tgt    <= tgt_n;
      j_q    <= j_n;
      k_q    <= k_n;
      done_q <= done_n;
      err_q  <= err_n;
      mask_q <= mask_n;
      cnt_q  <= cnt_n;
      retry  <= retry_n;
    end
  end

  assign bus.cmd_ready   = (state == IDLE);
  assign bus.j_out       = j_q;
  assign bus.k_out       = k_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;
  assign bus.fail_mask   = mask_q;
  assign bus.drive_count = cnt_q;
endmodule
